// File: rtl/recip_div_unit.sv
// Restoring-division reciprocal engine: Quotient = floor(2^(W-1)/Divisor), one bit per clock.
// Build option RECIP_ROUND_EN adds a rounding step for half-LSB upward rounding.
module recip_div_unit #(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [W-1:0] Divisor,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Quotient,
  output logic         DivByZero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RND  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic             start_q;
  logic [W-1:0]     dreg;
  logic [W:0]       rem;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     q;
  logic             dz;

  logic             accept;
  logic             div_bit;
  logic [W:0]       t;
  logic [W:0]       dext;
  logic             ge;
  logic [W:0]       rem_nxt;
  logic [W-1:0]     q_nxt;

  assign accept  = Start & ~start_q & (state == S_IDLE);
  assign div_bit = (cnt == CNT_W'(W-1));
  assign dext    = {1'b0, dreg};
  assign t       = {rem[W-1:0], div_bit};

  // rem[W] set would mean {rem,bit} exceeds any W-bit divisor
  always_comb begin
    ge      = rem[W] | (t >= dext);
    rem_nxt = t;
    q_nxt   = q;
    if (ge) begin
      rem_nxt = t - dext;
      q_nxt   = q | (W'(1) << cnt);
    end
  end

`ifdef RECIP_ROUND_EN
  logic guard;
  assign guard = rem[W] | ({rem[W-1:0], 1'b0} >= dext);
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      dreg      <= '0;
      rem       <= '0;
      cnt       <= '0;
      q         <= '0;
      dz        <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      DivByZero <= 1'b0;
    end else begin
      start_q <= Start;
      Done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            dreg <= Divisor;
            rem  <= '0;
            cnt  <= CNT_W'(W-1);
            if (Divisor == '0) begin
              q     <= '1;
              dz    <= 1'b1;
              state <= S_DONE;
            end else begin
              q     <= '0;
              dz    <= 1'b0;
              Busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          if (cnt == '0) begin
`ifdef RECIP_ROUND_EN
            state <= S_RND;
`else
            Busy  <= 1'b0;
            state <= S_DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef RECIP_ROUND_EN
        S_RND: begin
          q     <= q + W'(guard);
          Busy  <= 1'b0;
          state <= S_DONE;
        end
`endif
        S_DONE: begin
          Quotient  <= q;
          DivByZero <= dz;
          Done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_div_unit.sv
// Directed bench for recip_div_unit: vector table plus overlap-start and
// mid-run reset sequences.
module tb_recip_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Divisor = '0;
  logic        Busy;
  logic        Done;
  logic [15:0] Quotient;
  logic        DivByZero;

  int errors = 0;
  int checks = 0;

  recip_div_unit dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Divisor(Divisor),
    .Busy(Busy),
    .Done(Done),
    .Quotient(Quotient),
    .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

`ifdef RECIP_ROUND_EN
  localparam int LAT = 18;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 17;
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [15:0] d;
    logic [15:0] q_trunc;
    logic [15:0] q_round;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] d, input bit inject,
                        output logic [15:0] q, output logic dz,
                        output int lat, output bit busy_seen,
                        output bit overlap, output int dones,
                        output bit held);
    lat = -1; q = '0; dz = 1'b0;
    busy_seen = 1'b0; overlap = 1'b0; dones = 0; held = 1'b1;
    @(negedge Clk);
    Divisor = d;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (Busy) busy_seen = 1'b1;
      if (Busy && Done) overlap = 1'b1;
      if (inject && n == 4) begin
        Start = 1'b1;
        Divisor = 16'h0003;
      end
      if (inject && n == 6) Start = 1'b0;
      if (Done) begin
        dones++;
        if (lat < 0) begin
          lat = n;
          q = Quotient;
          dz = DivByZero;
        end
      end else if (lat >= 0 && (Quotient !== q || DivByZero !== dz)) begin
        held = 1'b0;
      end
    end
  endtask

  vec_t        vecs[8];
  logic [15:0] q;
  logic        dz;
  int          lat;
  int          dones;
  bit          busy_seen;
  bit          overlap;
  bit          held;
  int          late_dones;

  initial begin
    vecs[0] = '{16'h0004, 16'h2000, 16'h2000, 1'b0, LAT};
    vecs[1] = '{16'h0003, 16'h2AAA, 16'h2AAB, 1'b0, LAT};
    vecs[2] = '{16'h0001, 16'h8000, 16'h8000, 1'b0, LAT};
    vecs[3] = '{16'hFFFF, 16'h0000, 16'h0001, 1'b0, LAT};
    vecs[4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b1, 1};
    vecs[5] = '{16'h8000, 16'h0001, 16'h0001, 1'b0, LAT};
    vecs[6] = '{16'h0005, 16'h1999, 16'h199A, 1'b0, LAT};
    vecs[7] = '{16'h0007, 16'h1249, 16'h1249, 1'b0, LAT};

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_quot", 32'(Quotient), 32'd0);
    chk("reset_dz", 32'(DivByZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].d, 1'b0, q, dz, lat, busy_seen, overlap, dones, held);
      chk($sformatf("quot_d%0h", vecs[i].d), 32'(q),
          32'(RND ? vecs[i].q_round : vecs[i].q_trunc));
      chk($sformatf("dz_d%0h", vecs[i].d), 32'(dz), 32'(vecs[i].dz));
      chk($sformatf("lat_d%0h", vecs[i].d), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("dones_d%0h", vecs[i].d), 32'(dones), 32'd1);
      chk($sformatf("busy_d%0h", vecs[i].d), 32'(busy_seen),
          32'(!vecs[i].dz));
      chk($sformatf("overlap_d%0h", vecs[i].d), 32'(overlap), 32'd0);
      chk($sformatf("held_d%0h", vecs[i].d), 32'(held), 32'd1);
    end

    // Start edge with a new divisor while busy must be ignored
    run_op(16'h0004, 1'b1, q, dz, lat, busy_seen, overlap, dones, held);
    chk("ovl_quot", 32'(q), 32'h2000);
    chk("ovl_lat", 32'(lat), 32'(LAT));
    chk("ovl_dones", 32'(dones), 32'd1);

    // Asynchronous reset in the middle of a run
    @(negedge Clk);
    Divisor = 16'h0007;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #2;
    chk("midrun_busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b0;
    #1;
    chk("midrun_busy", 32'(Busy), 32'd0);
    chk("midrun_done", 32'(Done), 32'd0);
    chk("midrun_quot", 32'(Quotient), 32'd0);
    chk("midrun_dz", 32'(DivByZero), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    late_dones = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge Clk); #1;
      if (Done || Busy) late_dones++;
    end
    chk("midrun_no_done", 32'(late_dones), 32'd0);
    run_op(16'h0005, 1'b0, q, dz, lat, busy_seen, overlap, dones, held);
    chk("after_rst_quot", 32'(q), RND ? 32'h199A : 32'h1999);
    chk("after_rst_lat", 32'(lat), 32'(LAT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
